// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide memory port between fetch (IF) and
// data memory (DM); one transaction at a time, data has fixed priority.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_req_i, if_addr_i   fetch request (held until if_ready_o)
//   if_rdata_o            fetched word, valid with if_ready_o
//   if_ready_o            one-cycle fetch completion pulse
//   if_stall_o            if_req_i && !if_ready_o
//   dm_req_i, dm_we_i     data request, write enable
//   dm_be_i, dm_addr_i    byte enables, byte address
//   dm_wdata_i            write data
//   dm_rdata_o            read word, valid with dm_ready_o
//   dm_ready_o            one-cycle data completion pulse (reads and writes)
//   dm_stall_o            dm_req_i && !dm_ready_o
//   mem_req_o .. mem_wdata_o  registered memory request, held until ack
//   mem_ack_i, mem_rdata_i    memory completion and read data
//   conflict_cnt_o        saturating count of cycles where both were eligible
module mem_port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_req_i,
    input  logic [31:0]      if_addr_i,
    output logic [31:0]      if_rdata_o,
    output logic             if_ready_o,
    output logic             if_stall_o,
    input  logic             dm_req_i,
    input  logic             dm_we_i,
    input  logic [3:0]       dm_be_i,
    input  logic [31:0]      dm_addr_i,
    input  logic [31:0]      dm_wdata_i,
    output logic [31:0]      dm_rdata_o,
    output logic             dm_ready_o,
    output logic             dm_stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             mem_req_d;
    logic             mem_we_d;
    logic [3:0]       mem_be_d;
    logic [31:0]      mem_addr_d;
    logic [31:0]      mem_wdata_d;
    logic             if_ready_d;
    logic             dm_ready_d;
    logic [31:0]      if_rdata_d;
    logic [31:0]      dm_rdata_d;
    logic [CNT_W-1:0] cnt_d;

    logic if_elig;
    logic dm_elig;
    logic cnt_full;

    // A request seen in its own ready cycle is the stale copy of the one
    // just completed; masking it prevents a duplicate transaction.
    assign if_elig  = if_req_i && !if_ready_o;
    assign dm_elig  = dm_req_i && !dm_ready_o;
    assign cnt_full = &conflict_cnt_o;

    assign if_stall_o = if_req_i && !if_ready_o;
    assign dm_stall_o = dm_req_i && !dm_ready_o;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_be_d    = mem_be_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_o;
        dm_rdata_d  = dm_rdata_o;
        cnt_d       = conflict_cnt_o;

        unique case (state_q)
            IDLE: begin
                // Data wins: the memory-stage instruction is older.
                if (dm_elig) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_be_d    = dm_we_i ? dm_be_i : 4'b1111;
                    mem_addr_d  = {dm_addr_i[31:2], 2'b00};
                    mem_wdata_d = dm_wdata_i;
                    if (if_elig && !cnt_full) begin
                        cnt_d = conflict_cnt_o + CNT_W'(1);
                    end
                end else if (if_elig) begin
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'b1111;
                    mem_addr_d = {if_addr_i[31:2], 2'b00};
                end
            end
            BUSY_IF: begin
                if (mem_ack_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata_i;
                    if_ready_d = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ack_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = mem_rdata_i;
                    dm_ready_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_be_o       <= 4'b0000;
            mem_addr_o     <= 32'h0;
            mem_wdata_o    <= 32'h0;
            if_ready_o     <= 1'b0;
            dm_ready_o     <= 1'b0;
            if_rdata_o     <= 32'h0;
            dm_rdata_o     <= 32'h0;
            conflict_cnt_o <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_o      <= mem_req_d;
            mem_we_o       <= mem_we_d;
            mem_be_o       <= mem_be_d;
            mem_addr_o     <= mem_addr_d;
            mem_wdata_o    <= mem_wdata_d;
            if_ready_o     <= if_ready_d;
            dm_ready_o     <= dm_ready_d;
            if_rdata_o     <= if_rdata_d;
            dm_rdata_o     <= dm_rdata_d;
            conflict_cnt_o <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the shared port.
module tb_mem_port_arbiter;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             if_req;
    logic [31:0]      if_addr;
    logic [31:0]      if_rdata_o;
    logic             if_ready_o;
    logic             if_stall_o;
    logic             dm_req;
    logic             dm_we;
    logic [3:0]       dm_be;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata_o;
    logic             dm_ready_o;
    logic             dm_stall_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [3:0]       mem_be_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] conflict_cnt_o;

    mem_port_arbiter #(.CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_rdata_o     (if_rdata_o),
        .if_ready_o     (if_ready_o),
        .if_stall_o     (if_stall_o),
        .dm_req_i       (dm_req),
        .dm_we_i        (dm_we),
        .dm_be_i        (dm_be),
        .dm_addr_i      (dm_addr),
        .dm_wdata_i     (dm_wdata),
        .dm_rdata_o     (dm_rdata_o),
        .dm_ready_o     (dm_ready_o),
        .dm_stall_o     (dm_stall_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ack_i      (mem_ack),
        .mem_rdata_i    (mem_rdata),
        .conflict_cnt_o (conflict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: who owns the port (0 none, 1 fetch, 2 data) and the
    // transaction it is carrying, plus what each requester has seen.
    int          m_owner;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_if_rdy;
    logic        m_dm_rdy;
    logic [31:0] m_if_rd;
    logic [31:0] m_dm_rd;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_we     = 1'b0;
        m_be     = 4'h0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        m_if_rdy = 1'b0;
        m_dm_rdy = 1'b0;
        m_if_rd  = 32'h0;
        m_dm_rd  = 32'h0;
        m_cnt    = 0;
    endtask

    task automatic model_update();
        logic ife;
        logic dme;
        logic n_if;
        logic n_dm;
        if (rst) begin
            model_reset();
            return;
        end
        ife  = if_req && !m_if_rdy;
        dme  = dm_req && !m_dm_rdy;
        n_if = 1'b0;
        n_dm = 1'b0;
        if (m_owner == 0) begin
            if (dme) begin
                m_owner = 2;
                m_we    = dm_we;
                m_be    = dm_we ? dm_be : 4'hf;
                m_addr  = dm_addr & ~32'h3;
                m_wdata = dm_wdata;
                if (ife && m_cnt < CNT_MAX) m_cnt++;
            end else if (ife) begin
                m_owner = 1;
                m_we    = 1'b0;
                m_be    = 4'hf;
                m_addr  = if_addr & ~32'h3;
            end
        end else if (mem_ack) begin
            if (m_owner == 1) begin
                m_if_rd = mem_rdata;
                n_if    = 1'b1;
            end else begin
                m_dm_rd = mem_rdata;
                n_dm    = 1'b1;
            end
            m_owner = 0;
        end
        m_if_rdy = n_if;
        m_dm_rdy = n_dm;
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic tick();
        #1;
        chk("if_ready", 32'(if_ready_o), 32'(m_if_rdy));
        chk("dm_ready", 32'(dm_ready_o), 32'(m_dm_rdy));
        chk("if_rdata", if_rdata_o, m_if_rd);
        chk("dm_rdata", dm_rdata_o, m_dm_rd);
        chk("mem_req", 32'(mem_req_o), 32'(m_owner != 0));
        if (m_owner != 0) begin
            chk("mem_we", 32'(mem_we_o), 32'(m_we));
            chk("mem_be", 32'(mem_be_o), 32'(m_be));
            chk("mem_addr", mem_addr_o, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("if_stall", 32'(if_stall_o), 32'(if_req && !m_if_rdy));
        chk("dm_stall", 32'(dm_stall_o), 32'(dm_req && !m_dm_rdy));
        chk("conflict_cnt", 32'(conflict_cnt_o), 32'(m_cnt));
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = 32'h0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_be     = 4'h0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Fetch and data read arrive together; data first, fetch in the
    // data ready cycle, one idle memory cycle between them.
    task automatic conflict_pair(input int exp_cnt);
        if_req  = 1'b1;
        if_addr = 32'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        #1;
        chk("pair_dm_addr", mem_addr_o, 32'h200);
        chk("pair_dm_be", 32'(mem_be_o), 32'hf);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("pair_dm_ready", 32'(dm_ready_o), 32'h1);
        chk("pair_dm_rdata", dm_rdata_o, 32'h1111_1111);
        chk("pair_mem_gap", 32'(mem_req_o), 32'h0);
        tick();
        dm_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        #1;
        chk("pair_if_addr", mem_addr_o, 32'h100);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("pair_if_ready", 32'(if_ready_o), 32'h1);
        chk("pair_if_rdata", if_rdata_o, 32'h2222_2222);
        chk("pair_cnt", 32'(conflict_cnt_o), 32'(exp_cnt));
        tick();
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        int wcnt;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_be", 32'(mem_be_o), 32'h0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_cnt", 32'(conflict_cnt_o), 32'h0);
        do_reset();

        // Lone fetch, zero-wait memory, stale request in the ready cycle.
        if_req  = 1'b1;
        if_addr = 32'h0040_0006;
        #1;
        chk("fetch_stall_c0", 32'(if_stall_o), 32'h1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h2008_0005;
        #1;
        chk("fetch_addr", mem_addr_o, 32'h0040_0004);
        chk("fetch_be", 32'(mem_be_o), 32'hf);
        chk("fetch_stall_c1", 32'(if_stall_o), 32'h1);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h5555_5555;
        #1;
        chk("fetch_ready", 32'(if_ready_o), 32'h1);
        chk("fetch_rdata", if_rdata_o, 32'h2008_0005);
        chk("fetch_stall_c2", 32'(if_stall_o), 32'h0);
        tick();
        if_req = 1'b0;
        #1;
        chk("stale_no_req", 32'(mem_req_o), 32'h0);
        chk("fetch_ready_once", 32'(if_ready_o), 32'h0);
        tick();
        tick();

        // Simultaneous requests, then saturation of the 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            conflict_pair(i < CNT_MAX ? i + 1 : CNT_MAX);
        end

        // Data write with three wait states.
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 32'h8;
        dm_wdata = 32'hDEAD_BEEF;
        tick();
        for (int k = 1; k <= 4; k++) begin
            mem_ack  = (k == 4);
            dm_wdata = (k == 2) ? 32'h0 : 32'hDEAD_BEEF;
            #1;
            chk("wr_req", 32'(mem_req_o), 32'h1);
            chk("wr_we", 32'(mem_we_o), 32'h1);
            chk("wr_be", 32'(mem_be_o), 32'h3);
            chk("wr_addr", mem_addr_o, 32'h8);
            chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            tick();
        end
        mem_ack = 1'b0;
        #1;
        chk("wr_ready", 32'(dm_ready_o), 32'h1);
        tick();
        dm_req = 1'b0;
        tick();

        // Reset while a fetch is pending, then a late ack.
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();
        tick();
        rst    = 1'b1;
        if_req = 1'b0;
        #1;
        chk("rmid_req_c2", 32'(mem_req_o), 32'h1);
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rmid_req_c3", 32'(mem_req_o), 32'h0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rmid_no_ready", 32'(if_ready_o), 32'h0);
        chk("rmid_cnt", 32'(conflict_cnt_o), 32'h0);
        tick();

        // Randomized traffic with random wait states, stray acks and resets.
        wcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (rst) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end else begin
                if (if_req && m_if_rdy) begin
                    if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                end else if (!if_req) begin
                    if_req  = ($urandom_range(0, 2) != 0);
                    if_addr = $urandom;
                end
                if (dm_req && m_dm_rdy) begin
                    if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
                end else if (!dm_req) begin
                    dm_req   = ($urandom_range(0, 2) == 0);
                    dm_we    = ($urandom_range(0, 1) == 0);
                    dm_be    = 4'($urandom_range(0, 15));
                    dm_addr  = $urandom;
                    dm_wdata = $urandom;
                end
            end
            if (m_owner != 0) begin
                if (wcnt == 0) begin
                    mem_ack = 1'b1;
                end else begin
                    mem_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
                wcnt    = $urandom_range(0, 3);
            end
            mem_rdata = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one external word-wide memory port between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage pipeline. It accepts one outstanding request per requester and drives a single request/acknowledge transaction to memory at a time. It returns read data and a one-cycle ready pulse to the granted requester, and exports per-requester stall signals that the pipeline stall/flush logic ORs into its F/D/E stall terms.

## Interface

Parameters:
- `CNT_W`, default 16: width of the saturating conflict counter.

Ports (clock and reset first):
- `clk_i` in 1: clock. One clock domain only.
- `rst_i` in 1: reset, synchronous, active-high.
- `if_req_i` in 1: fetch request. Held high with a stable address until `if_ready_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_rdata_o` out 32: fetched word. Valid while `if_ready_o` is high.
- `if_ready_o` out 1: one-cycle completion pulse for fetch.
- `if_stall_o` out 1: `if_req_i && !if_ready_o`. Combinational.
- `dm_req_i` in 1: data request. Held high with stable `dm_*` inputs until `dm_ready_o`.
- `dm_we_i` in 1: 1 means write, 0 means read.
- `dm_be_i` in 4: write byte enables.
- `dm_addr_i` in 32: data byte address.
- `dm_wdata_i` in 32: write data.
- `dm_rdata_o` out 32: read word. Valid while `dm_ready_o` is high.
- `dm_ready_o` out 1: one-cycle completion pulse for data. Pulses for both reads and writes.
- `dm_stall_o` out 1: `dm_req_i && !dm_ready_o`. Combinational.
- `mem_req_o` out 1: memory request. Held until `mem_ack_i`.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out 4: byte enables. Forced to 4'b1111 for fetch and for data reads.
- `mem_addr_o` out 32: word address `{addr[31:2], 2'b00}`.
- `mem_wdata_o` out 32: write data.
- `mem_ack_i` in 1: memory completion. Sampled only while `mem_req_o` is high.
- `mem_rdata_i` in 32: read data. Valid with `mem_ack_i`.
- `conflict_cnt_o` out CNT_W: number of arbitration cycles in which both requests were eligible.

## Operation

- FSM states: IDLE, BUSY_IF, BUSY_DM.
- Eligibility: a request is eligible in IDLE only if its own ready pulse is low in that cycle. This masks the stale request still present in the cycle its ready pulse is high.
- IDLE, data eligible: latch the `dm_*` fields into the memory output registers and go to BUSY_DM. If fetch is also eligible, increment `conflict_cnt_o`.
- IDLE, only fetch eligible: latch `if_addr_i` and set `we=0` and `be=1111`, then go to BUSY_IF.
- IDLE, neither eligible: remain in IDLE.
- Priority is fixed: data over fetch. The memory-stage instruction is older, and the pipeline stalls fetch whenever data stalls, so fetch cannot deadlock.
- BUSY_x: `mem_req_o` and all `mem_*` outputs are registered and held constant. On `mem_ack_i`:
  - register `mem_rdata_i` into `x_rdata_o`;
  - assert `x_ready_o` for the next cycle only;
  - drop `mem_req_o` and return to IDLE.
- BUSY_x without ack: hold indefinitely. There is no timeout.
- `mem_ack_i` in IDLE is ignored.
- Requester inputs that change while that requester is BUSY are ignored. The latched copy is used.
- `conflict_cnt_o` saturates at all-ones and does not wrap.
- Rdata registers hold their last value when not ready. For writes, `dm_rdata_o` is the value returned by memory and is don't-care to consumers.

## Timing

- Reset values: state IDLE; `mem_req_o`, `mem_we_o`, `if_ready_o`, `dm_ready_o` = 0; `mem_be_o`, `mem_addr_o`, `mem_wdata_o`, `if_rdata_o`, `dm_rdata_o` = 0; `conflict_cnt_o` = 0.
- Latency, cycle-numbered:
  - cycle 0: request sampled in IDLE;
  - cycle 1: `mem_req_o` high;
  - cycle N ≥ 1: `mem_ack_i` high;
  - cycle N+1: ready pulse and rdata valid, state IDLE.
- With zero-wait memory (ack in cycle 1), total latency is 2 cycles.
- Back-to-back transactions: the next grant decision is made in the ready cycle N+1, so the next `mem_req_o` rises in cycle N+2. There is exactly one idle memory cycle between transactions.
- Reset mid-transaction: on the reset edge, `mem_req_o` drops the next cycle. No ready pulse is generated, and a late ack is ignored. Requesters are reset by the same `rst_i`.
- Both requests arriving in the same cycle: data is granted first. Fetch is granted in DM's ready cycle, because fetch is eligible and data is masked.

## Test plan

- Lone fetch, zero-wait memory: `if_req_i=1`, `if_addr_i=0x0040_0006`, ack in cycle 1 with rdata `0x2008_0005` -> `mem_addr_o=0x0040_0004` and `mem_be_o=1111` in cycle 1; `if_ready_o` pulses only in cycle 2 with `if_rdata_o=0x2008_0005`; `if_stall_o` is high in cycles 0–1.
- Simultaneous requests: fetch 0x100 and data read 0x200 in cycle 0, with 0-wait ack -> memory sees 0x200 in cycle 1 and `dm_ready_o` in cycle 2; memory sees 0x100 in cycle 3 and `if_ready_o` in cycle 4; `conflict_cnt_o=1`.
- Data write with wait states: `dm_we_i=1`, `be=0011`, addr 0x8, wdata 0xDEAD_BEEF, ack delayed to cycle 4 -> `mem_req_o`, `we`, `be`, `addr`, `wdata` are stable in cycles 1–4; `dm_ready_o` pulses in cycle 5.
- Stale-request mask: fetch completes and `if_req_i` stays high in the ready cycle, then drops -> exactly one memory transaction is issued.
- Reset mid-transaction: assert `rst_i` in cycle 2 of a pending fetch, then ack in cycle 3 -> `mem_req_o=0` from cycle 3; no `if_ready_o`; `conflict_cnt_o=0`.
- Saturation: with `CNT_W=2`, run 5 conflicting arbitrations -> `conflict_cnt_o` stays at 3.
